reg_bank_exec_seq: RTL and testbench

Multi-cycle execute sequencer that sits directly upstream of the 8x8 register bank and drives its read and write ports. It accepts one register-register or immediate instruction over a valid/ready handshake and reads two operands through the bank's combinational read ports. It then computes an 8-bit ALU result with flags and writes the result back. Back-to-back read-after-write is safe because the sequencer waits out the bank's two-edge write latency before accepting the next instruction.

---
 rtl/exec_pkg.sv | 27 ++
 rtl/reg_bank_exec_alu8_comb.sv | 52 +++++
 rtl/reg_bank_exec_seq.sv | 176 +++++++++++++++++
 tb/tb_reg_bank_exec_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types for the register-bank execute sequencer.
// Opcode and FSM state encodings plus default sizes.
package exec_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_AW    = 3;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_ADDI = 3'd5,
    OP_SHL  = 3'd6,
    OP_LI   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_SETTLE
  } state_e;

endpackage

// File: rtl/reg_bank_exec_alu8_comb.sv
// 8-bit combinational ALU: result, carry/borrow and zero flag.
// Registered by the sequencer at the end of EXEC.
module alu8_comb
  import exec_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] imm,
  input  op_e        op,
  output logic [7:0] result,
  output logic       carry,
  output logic       zero
);

  logic [8:0]  sum;
  logic [15:0] sh;

  always_comb begin
    sum    = '0;
    sh     = {8'h00, a} << b[2:0];
    result = '0;
    carry  = 1'b0;
    unique case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[7:0];
        carry  = sum[8];
      end
      OP_SUB: begin
        // bit 8 of the 9-bit difference is the borrow
        sum    = {1'b0, a} - {1'b0, b};
        result = sum[7:0];
        carry  = sum[8];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_ADDI: begin
        sum    = {1'b0, a} + {1'b0, imm};
        result = sum[7:0];
        carry  = sum[8];
      end
      OP_SHL: begin
        result = sh[7:0];
        carry  = sh[8];
      end
      OP_LI: result = imm;
    endcase
    zero = (result == 8'h00);
  end

endmodule

// File: rtl/reg_bank_exec_seq.sv
// Multi-cycle execute sequencer driving the 8x8 register bank.
// IDLE -> READ -> EXEC -> WRITE -> SETTLE -> IDLE, one instr at a time.
module reg_bank_exec_seq
  import exec_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int AW            = DEF_AW,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    rd_addr,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  input  logic [WIDTH-1:0] imm,
  output logic [AW-1:0]    ra1,
  output logic [AW-1:0]    ra2,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  output logic             we,
  output logic [AW-1:0]    wa,
  output logic [WIDTH-1:0] wd,
  output logic             done,
  output logic             flag_z,
  output logic             flag_c
);

  localparam int CW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [AW-1:0]    ra1_q, ra1_d;
  logic [AW-1:0]    ra2_q, ra2_d;
  logic             we_q, we_d;
  logic [AW-1:0]    wa_q, wa_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic             done_q, done_d;
  logic             rdy_q, rdy_d;
  logic             z_q, z_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [7:0] alu_res;
  logic       alu_c;
  logic       alu_z;

  alu8_comb u_alu (
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_q),
    .op     (op_q),
    .result (alu_res),
    .carry  (alu_c),
    .zero   (alu_z)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    a_d     = a_q;
    b_d     = b_q;
    ra1_d   = ra1_q;
    ra2_d   = ra2_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    done_d  = 1'b0;
    rdy_d   = rdy_q;
    z_d     = z_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d    = op_e'(op);
          rd_d    = rd_addr;
          imm_d   = imm;
          ra1_d   = rs1_addr;
          ra2_d   = rs2_addr;
          rdy_d   = 1'b0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        a_d     = rd1;
        b_d     = rd2;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        wd_d    = alu_res;
        wa_d    = rd_q;
        z_d     = alu_z;
        c_d     = alu_c;
        // register 0 is hardwired: never write it
        we_d    = (rd_q != '0);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        cnt_d   = CW'(SETTLE_CYCLES - 1);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      rd_q    <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ra1_q   <= ra1_d;
      ra2_q   <= ra2_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
      z_q     <= z_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_ready = rdy_q;
  assign ra1         = ra1_q;
  assign ra2         = ra2_q;
  assign we          = we_q;
  assign wa          = wa_q;
  assign wd          = wd_q;
  assign done        = done_q;
  assign flag_z      = z_q;
  assign flag_c      = c_q;

endmodule

// File: tb/tb_reg_bank_exec_seq.sv
// Bench for reg_bank_exec_seq with a behavioural 8x8 bank.
// Vector table plus back-to-back RAW and mid-write reset sequences.
module tb_reg_bank_exec_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] op = '0;
  logic [2:0] rd_addr = '0;
  logic [2:0] rs1_addr = '0;
  logic [2:0] rs2_addr = '0;
  logic [7:0] imm = '0;
  logic [2:0] ra1, ra2;
  logic [7:0] rd1, rd2;
  logic       we;
  logic [2:0] wa;
  logic [7:0] wd;
  logic       done;
  logic       flag_z, flag_c;

  always #5 clk = ~clk;

  reg_bank_exec_seq dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .op          (op),
    .rd_addr     (rd_addr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .imm         (imm),
    .ra1         (ra1),
    .ra2         (ra2),
    .rd1         (rd1),
    .rd2         (rd2),
    .we          (we),
    .wa          (wa),
    .wd          (wd),
    .done        (done),
    .flag_z      (flag_z),
    .flag_c      (flag_c)
  );

  // bank: write latched on one edge, visible after the next
  logic [7:0] bank [8];
  logic       bank_clr = 1'b1;
  logic       p_we = 1'b0;
  logic [2:0] p_wa = '0;
  logic [7:0] p_wd = '0;

  always @(posedge clk) begin
    if (bank_clr) begin
      for (int i = 0; i < 8; i++) bank[i] <= 8'h00;
      p_we <= 1'b0;
    end else begin
      if (p_we && p_wa != 3'd0) bank[p_wa] <= p_wd;
      p_we <= we;
      p_wa <= wa;
      p_wd <= wd;
    end
  end

  assign rd1 = bank[ra1];
  assign rd2 = bank[ra2];

  typedef struct {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [7:0] imm;
    logic [7:0] res;
    logic       z;
    logic       c;
  } vec_t;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   ndone = 0;
  int   we_cnt = 0;
  vec_t cur;
  vec_t e;
  vec_t exp_q[$];
  int   acc_cyc[$];
  vec_t vecs[15];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(logic [2:0] o, logic [2:0] d,
                              logic [2:0] s1, logic [2:0] s2,
                              logic [7:0] im, logic [7:0] r,
                              logic z, logic c);
    vec_t v;
    v.op = o; v.rd = d; v.rs1 = s1; v.rs2 = s2;
    v.imm = im; v.res = r; v.z = z; v.c = c;
    return v;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst && instr_valid && instr_ready) begin
      exp_q.push_back(cur);
      acc_cyc.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (we) we_cnt++;
      if (done) begin
        ndone++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wd", wd, e.res);
          chk("flag_z", flag_z, e.z);
          chk("flag_c", flag_c, e.c);
          chk("we_pulses", we_cnt, (e.rd != 0) ? 1 : 0);
          chk("bank_rd", bank[e.rd], (e.rd != 0) ? e.res : 8'h00);
        end
        we_cnt = 0;
      end
    end
  end

  task automatic drive(vec_t v);
    cur      = v;
    op       = v.op;
    rd_addr  = v.rd;
    rs1_addr = v.rs1;
    rs2_addr = v.rs2;
    imm      = v.imm;
  endtask

  task automatic issue(vec_t v);
    int k;
    k = 0;
    @(negedge clk);
    while (!instr_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("ready_timeout", 0, 1);
    drive(v);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic wait_done(int n0);
    int k;
    k = 0;
    while (ndone == n0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    if (ndone == n0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, lowcnt, k;

    vecs[0]  = mk(3'd7, 3'd1, 3'd0, 3'd0, 8'h7F, 8'h7F, 0, 0);
    vecs[1]  = mk(3'd7, 3'd2, 3'd0, 3'd0, 8'h01, 8'h01, 0, 0);
    vecs[2]  = mk(3'd0, 3'd3, 3'd1, 3'd2, 8'h00, 8'h80, 0, 0);
    vecs[3]  = mk(3'd7, 3'd1, 3'd0, 3'd0, 8'hFF, 8'hFF, 0, 0);
    vecs[4]  = mk(3'd5, 3'd4, 3'd1, 3'd0, 8'h01, 8'h00, 1, 1);
    vecs[5]  = mk(3'd1, 3'd5, 3'd2, 3'd1, 8'h00, 8'h02, 0, 1);
    vecs[6]  = mk(3'd7, 3'd7, 3'd0, 3'd0, 8'h01, 8'h01, 0, 0);
    vecs[7]  = mk(3'd7, 3'd2, 3'd0, 3'd0, 8'h81, 8'h81, 0, 0);
    vecs[8]  = mk(3'd6, 3'd6, 3'd2, 3'd7, 8'h00, 8'h02, 0, 1);
    vecs[9]  = mk(3'd6, 3'd6, 3'd2, 3'd0, 8'h00, 8'h81, 0, 0);
    vecs[10] = mk(3'd2, 3'd3, 3'd1, 3'd2, 8'h00, 8'h81, 0, 0);
    vecs[11] = mk(3'd3, 3'd4, 3'd7, 3'd2, 8'h00, 8'h81, 0, 0);
    vecs[12] = mk(3'd4, 3'd5, 3'd2, 3'd2, 8'h00, 8'h00, 1, 0);
    vecs[13] = mk(3'd7, 3'd0, 3'd0, 3'd0, 8'h55, 8'h55, 0, 0);
    vecs[14] = mk(3'd1, 3'd6, 3'd1, 3'd7, 8'h00, 8'hFE, 0, 0);

    #12;
    chk("rst_ready", instr_ready, 1);
    chk("rst_we", we, 0);
    chk("rst_done", done, 0);
    chk("rst_wa_wd", {wa, wd}, 0);
    chk("rst_ra", {ra1, ra2}, 0);
    chk("rst_flags", {flag_z, flag_c}, 0);
    @(negedge clk);
    rst = 1'b1;
    bank_clr = 1'b0;

    for (int i = 0; i < 15; i++) begin
      n0 = ndone;
      issue(vecs[i]);
      wait_done(n0);
    end
    chk("r0_after_li", bank[0], 8'h00);

    // back-to-back RAW with valid held high
    acc_cyc.delete();
    @(negedge clk);
    drive(mk(3'd7, 3'd1, 3'd0, 3'd0, 8'h10, 8'h10, 0, 0));
    instr_valid = 1'b1;
    n0 = ndone;
    @(posedge clk);
    #1 drive(mk(3'd0, 3'd2, 3'd1, 3'd1, 8'h00, 8'h20, 0, 0));
    lowcnt = 0;
    k = 0;
    @(negedge clk);
    while (!instr_ready && k < 20) begin
      lowcnt++;
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    wait_done(n0 + 1);
    chk("ready_low_cycles", lowcnt, 4);
    if (acc_cyc.size() == 2)
      chk("accept_spacing", acc_cyc[1] - acc_cyc[0], 5);
    else
      chk("accept_count", acc_cyc.size(), 2);

    // reset asserted during the WRITE cycle
    n0 = ndone;
    issue(mk(3'd7, 3'd3, 3'd0, 3'd0, 8'hAA, 8'hAA, 0, 0));
    k = 0;
    while (!we && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("saw_write", we, 1);
    rst = 1'b0;
    #1;
    chk("rst_we_drop", we, 0);
    chk("rst_done_low", done, 0);
    chk("rst_ready_hi", instr_ready, 1);
    exp_q.delete();
    we_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("no_done_after_rst", ndone, n0);
    chk("ready_after_rst", instr_ready, 1);
    chk("r3_unchanged", bank[3], 8'h81);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
